hilo_mult_unit: RTL and testbench
=================================

// Module: hilo_mult_unit
// PURPOSE
//  Iterative 32x32 multiplier plus architectural HI/LO register pair for the pipelined MIPS core.
//  Sits in EX, downstream of the Controller; consumes its MoveToHi/MoveToLo/AddToHi/AddToLo/HiLoSel decode.
//  Serves mult/multu/madd/msub and mthi/mtlo, and returns HI or LO for mfhi/mflo.
//  Busy drives the hazard unit, which stalls any HI/LO consumer or new multiply while Busy=1.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are WIDTH each, product is 2*WIDTH
// PORTS
//  Clk          in   1      clock, rising edge
//  Rst          in   1      asynchronous, active-low reset
//  Start        in   1      launch multiply (Controller MoveToHi&MoveToLo, or AddToHi&AddToLo)
//  Signed       in   1      1=signed (mult/madd/msub), 0=unsigned (multu)
//  AccOp        in   2      00=load product, 01=HI:LO+=product, 10=HI:LO-=product, 11=load
//  A            in   WIDTH  rs operand
//  B            in   WIDTH  rt operand
//  MoveToHi     in   1      direct write HI<=WriteData (mthi); ignored if Start=1
//  MoveToLo     in   1      direct write LO<=WriteData (mtlo); ignored if Start=1
//  WriteData    in   WIDTH  data for direct writes
//  HiLoSel      in   1      ReadData select: 1=HI, 0=LO
//  ReadData     out  WIDTH  combinational HiLoSel ? Hi : Lo
//  Hi           out  WIDTH  HI register
//  Lo           out  WIDTH  LO register
//  Busy         out  1      high in MUL and WB states
//  Done         out  1      one-cycle pulse in WB state
// BEHAVIOUR
//  Reset (Rst=0, async): Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, counter=0, product acc=0.
//  Reset mid-operation aborts the multiply; HI/LO are cleared and no writeback occurs.
//  FSM:
//   - IDLE: Start=1 captures |A|,|B| (magnitude when Signed=1), sign=A[msb]^B[msb]&Signed,
//     and AccOp; goes to MUL with count=0.
//   - MUL: one shift-add step per cycle (radix-2, unsigned); after WIDTH cycles goes to WB.
//   - WB: Done=1; product P is negated if sign=1; result R is P, {Hi,Lo}+P or {Hi,Lo}-P per AccOp.
//     Arithmetic is modulo 2^(2*WIDTH).
//   - WB to IDLE: {Hi,Lo}<=R on that edge.
//  Timing:
//   - Start sampled at edge 0; MUL occupies cycles 1..WIDTH; WB is cycle WIDTH+1.
//   - New Hi/Lo are visible from cycle WIDTH+2, when Busy is already 0.
//  Handshake rules:
//   - Start while Busy=1 (MUL or WB) is ignored.
//   - MoveToHi/MoveToLo while Busy=1 are ignored; the hazard unit must stall instead.
//   - Direct writes are applied only in IDLE with Start=0, and HI and LO may be written in the same cycle.
//   - Start and MoveTo* in the same IDLE cycle: Start wins and the direct write is dropped.
//  ReadData/Hi/Lo always reflect the committed registers, never partial products.
//  Operand inputs need not be held after the Start edge.
// TESTING
//  1. Signed: Start, Signed=1, AccOp=00, A=7, B=-3 -> Done at cycle 33; Hi=FFFFFFFF, Lo=FFFFFFEB at cycle 34.
//  2. Unsigned: Signed=0, A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001; Busy high exactly cycles 1..33.
//  3. madd: preload via mthi=0, mtlo=FFFFFFFF; Start AccOp=01, Signed=1, A=2, B=1 -> Hi=1, Lo=1.
//     msub of the same operands then restores Hi=0, Lo=FFFFFFFF.
//  4. Start and MoveToHi (WriteData=1234) pulsed mid-MUL -> both ignored.
//     Result equals the first op only; Hi never shows 1234.
//  5. Rst low at cycle 10 of a multiply -> Hi=Lo=0, Busy=0 immediately.
//     No Done pulse; the next Start works normally.
//  6. HiLoSel toggled with Hi=AAAA0000, Lo=0000BBBB -> ReadData follows in the same cycle.
//     Start+MoveToLo in one IDLE cycle -> Lo unchanged by the direct write.

Source files
------------

// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 32x32 multiplier with the architectural HI/LO register pair.
// Serves mult/multu/madd/msub, mthi/mtlo, and mfhi/mflo reads for the EX stage.
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Signed,
  input  logic [1:0]       AccOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MoveToHi,
  input  logic             MoveToLo,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             HiLoSel,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     prod_q,   prod_d;
  logic                   sign_q,   sign_d;
  logic [1:0]             accop_q,  accop_d;
  logic [WIDTH-1:0]       hi_q,     hi_d;
  logic [WIDTH-1:0]       lo_q,     lo_d;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] accumulate(input logic [2*WIDTH-1:0] hilo,
                                                    input logic [2*WIDTH-1:0] mag,
                                                    input logic               neg,
                                                    input logic [1:0]         op);
    logic [2*WIDTH-1:0] p;
    p = neg ? (~mag + 1'b1) : mag;
    case (op)
      2'b01:   return hilo + p;
      2'b10:   return hilo - p;
      default: return p;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    accop_d  = accop_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = {{WIDTH{1'b0}}, magnitude(A, Signed)};
          mplier_d = magnitude(B, Signed);
          prod_d   = '0;
          cnt_d    = '0;
          sign_d   = (A[WIDTH-1] ^ B[WIDTH-1]) & Signed;
          accop_d  = AccOp;
          state_d  = S_MUL;
        end else begin
          // Direct writes only land when no multiply is being launched.
          if (MoveToHi) hi_d = WriteData;
          if (MoveToLo) lo_d = WriteData;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = S_WB;
      end
      S_WB: begin
        {hi_d, lo_d} = accumulate({hi_q, lo_q}, prod_q, sign_q, accop_q);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      accop_q  <= 2'b00;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      sign_q   <= sign_d;
      accop_q  <= accop_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_WB);
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign ReadData = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed and randomized checks of hilo_mult_unit against a 64-bit arithmetic model of HI:LO.
module tb_hilo_mult_unit;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, Signed, MoveToHi, MoveToLo, HiLoSel;
  logic [1:0]  AccOp;
  logic [31:0] A, B, WriteData;
  logic [31:0] ReadData, Hi, Lo;
  logic        Busy, Done;

  int checks   = 0;
  int failures = 0;
  logic [63:0] hl_m;

  hilo_mult_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed), .AccOp(AccOp),
    .A(A), .B(B), .MoveToHi(MoveToHi), .MoveToLo(MoveToLo), .WriteData(WriteData),
    .HiLoSel(HiLoSel), .ReadData(ReadData), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = sg ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction

  function automatic logic [63:0] ref_acc(input logic [63:0] old, input logic [1:0] op,
                                          input logic [63:0] p);
    if (op == 2'b01) return old + p;
    if (op == 2'b10) return old - p;
    return p;
  endfunction

  task automatic move(input logic hi_en, input logic lo_en, input logic [31:0] data);
    MoveToHi = hi_en; MoveToLo = lo_en; WriteData = data;
    step();
    MoveToHi = 1'b0; MoveToLo = 1'b0;
    if (hi_en) hl_m[63:32] = data;
    if (lo_en) hl_m[31:0]  = data;
    check("move_hilo", {Hi, Lo}, hl_m);
  endtask

  task automatic run_op(input logic sg, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject, input bit collide);
    logic [63:0] old, expv;
    old  = hl_m;
    expv = ref_acc(old, op, ref_prod(sg, a, b));
    Signed = sg; AccOp = op; A = a; B = b; Start = 1'b1;
    if (collide) begin MoveToLo = 1'b1; WriteData = 32'hDEAD0001; end
    step();
    Start = 1'b0; MoveToLo = 1'b0;
    A = $urandom; B = $urandom; Signed = 1'($urandom); AccOp = 2'($urandom);
    for (int c = 1; c <= 33; c++) begin
      check("busy_run", 64'(Busy), 64'd1);
      check("done_run", 64'(Done), 64'(c == 33));
      check("hold_hilo", {Hi, Lo}, old);
      if (inject && (c == 5 || c == 33)) begin
        Start = 1'b1; MoveToHi = 1'b1; MoveToLo = 1'b1; WriteData = 32'd1234;
      end else begin
        Start = 1'b0; MoveToHi = 1'b0; MoveToLo = 1'b0;
      end
      step();
    end
    Start = 1'b0; MoveToHi = 1'b0; MoveToLo = 1'b0;
    hl_m = expv;
    check("busy_after", 64'(Busy), 64'd0);
    check("done_after", 64'(Done), 64'd0);
    check("result_hilo", {Hi, Lo}, expv);
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Signed = 1'b0; AccOp = 2'b00; A = '0; B = '0;
    MoveToHi = 1'b0; MoveToLo = 1'b0; WriteData = '0; HiLoSel = 1'b0;
    hl_m = '0;
    step(); step();
    check("rst_hilo", {Hi, Lo}, 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_read", 64'(ReadData), 64'd0);
    Rst = 1'b1;
    step();

    // Signed 7 * -3
    run_op(1'b1, 2'b00, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
    check("t1_const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);

    // Unsigned max * max
    run_op(1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("t2_const", {Hi, Lo}, 64'hFFFFFFFE_00000001);

    // madd then msub
    move(1'b1, 1'b0, 32'h0);
    move(1'b0, 1'b1, 32'hFFFFFFFF);
    run_op(1'b1, 2'b01, 32'd2, 32'd1, 1'b0, 1'b0);
    check("t3_madd", {Hi, Lo}, 64'h00000001_00000001);
    run_op(1'b1, 2'b10, 32'd2, 32'd1, 1'b0, 1'b0);
    check("t3_msub", {Hi, Lo}, 64'h00000000_FFFFFFFF);

    // Start/MoveTo pulses while busy are ignored
    run_op(1'b1, 2'b00, 32'hFFFFFF80, 32'd100, 1'b1, 1'b0);
    check("t4_const", {Hi, Lo}, 64'hFFFFFFFF_FFFFCE00);

    // Asynchronous reset mid-multiply
    Signed = 1'b0; AccOp = 2'b00; A = 32'd5; B = 32'd6; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    check("t5_busy_pre", 64'(Busy), 64'd1);
    Rst = 1'b0;
    #1;
    hl_m = '0;
    check("t5_hilo", {Hi, Lo}, 64'd0);
    check("t5_busy", 64'(Busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_nodone", 64'(Done), 64'd0);
    end
    Rst = 1'b1;
    step();
    for (int c = 0; c < 30; c++) begin
      check("t5_idle_done", 64'(Done), 64'd0);
      check("t5_idle_hilo", {Hi, Lo}, 64'd0);
      step();
    end
    run_op(1'b0, 2'b00, 32'd5, 32'd6, 1'b0, 1'b0);
    check("t5_restart", {Hi, Lo}, 64'd30);

    // ReadData select and Start/MoveToLo collision
    move(1'b1, 1'b0, 32'hAAAA0000);
    move(1'b0, 1'b1, 32'h0000BBBB);
    HiLoSel = 1'b1; #1;
    check("t6_read_hi", 64'(ReadData), 64'hAAAA0000);
    HiLoSel = 1'b0; #1;
    check("t6_read_lo", 64'(ReadData), 64'h0000BBBB);
    run_op(1'b0, 2'b01, 32'd3, 32'd4, 1'b0, 1'b1);
    check("t6_collide", {Hi, Lo}, 64'hAAAA0000_0000BBC7);
    HiLoSel = 1'b1; #1;
    check("t6_read_hi2", 64'(ReadData), 64'hAAAA0000);

    // Both registers written in one cycle
    move(1'b1, 1'b1, 32'h13579BDF);

    // Randomized operations including extreme operands
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h80000000;
      if (i == 1) begin ra = 32'h80000000; rb = 32'h80000000; end
      run_op(1'($urandom), 2'($urandom), ra, rb, bit'($urandom_range(0, 1)), 1'b0);
      HiLoSel = 1'($urandom); #1;
      check("rand_read", 64'(ReadData), 64'(HiLoSel ? hl_m[63:32] : hl_m[31:0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
